muldiv_sequencer: RTL and testbench

Sequences the iterative multiplier and divider cores on behalf of the CPU control unit. It accepts one HI/LO operation at a time, resets and launches the selected core, and polls its 2-bit state output until DONE. It then commits the result to the architectural HI/LO registers. It holds busy high for the whole operation so the control unit stalls MFHI/MFLO and further HI/LO operations.

---
 rtl/muldiv_sequencer_if.sv | 24 ++
 rtl/muldiv_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the CPU control unit and the multiply/divide sequencer.
interface muldiv_sequencer_if;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op_valid, op_code, op_a, op_b,
        input  op_ready, busy, done, error, div_zero, hi, lo
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b,
        output op_ready, busy, done, error, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Runs one HI/LO operation at a time on the iterative multiply/divide cores and commits HI/LO.
// Build macro MULDIV_DIVZERO_TRAP_EN: DIV by zero completes in IDLE with div_zero instead of launching the divider.
module muldiv_sequencer #(
    parameter int TIMEOUT = 48
) (
    input  logic              i_clock,
    input  logic              i_reset,
    muldiv_sequencer_if.slave io_op,
    output logic              o_unit_reset,
    output logic              o_mult_enable,
    output logic              o_div_enable,
    output logic [31:0]       o_unit_a,
    output logic [31:0]       o_unit_b,
    input  logic [1:0]        i_mult_state,
    input  logic [1:0]        i_div_state,
    input  logic [31:0]       i_mult_hi,
    input  logic [31:0]       i_mult_lo,
    input  logic [31:0]       i_div_hi,
    input  logic [31:0]       i_div_lo
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_LAUNCH  = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

    localparam logic [1:0] OP_MTHI   = 2'b10;
    localparam logic [1:0] OP_MTLO   = 2'b11;
    localparam logic [1:0] CORE_DONE = 2'd2;
    localparam logic [5:0] CNT_LAST  = 6'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_sel_div;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_unit_a;
    logic [31:0] r_unit_b;
    logic        r_done;
    logic        r_error;

    logic        w_accept;
    logic        w_start;
    logic        w_trap;
    logic        w_core_done;
    logic        w_abort;
    logic        w_capture;
    logic [1:0]  w_core_state;

    assign w_accept = io_op.op_valid & (r_state == S_IDLE);

`ifdef MULDIV_DIVZERO_TRAP_EN
    localparam logic [1:0] OP_DIV = 2'b01;
    logic r_div_zero;

    assign w_trap = w_accept & (io_op.op_code == OP_DIV) & (io_op.op_b == 32'd0);

    // div_zero accompanies the done of a trapped divide
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_div_zero <= 1'b0;
        end else begin
            r_div_zero <= w_trap;
        end
    end

    assign io_op.div_zero = r_div_zero;
`else
    assign w_trap         = 1'b0;
    assign io_op.div_zero = 1'b0;
`endif

    assign w_start      = w_accept & ~io_op.op_code[1] & ~w_trap;
    assign w_core_state = r_sel_div ? i_div_state : i_mult_state;
    assign w_core_done  = (w_core_state == CORE_DONE);
    assign w_capture    = (r_state == S_CAPTURE);
    // A core reporting DONE on the last allowed WAIT cycle still wins over the timeout
    assign w_abort      = (r_state == S_WAIT) & ~w_core_done & (r_cnt == CNT_LAST);

    // state register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_CLEAR;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_CLEAR:   w_next_state = S_LAUNCH;
            S_LAUNCH:  w_next_state = S_WAIT;
            S_WAIT: begin
                if (w_core_done) begin
                    w_next_state = S_CAPTURE;
                end else if (w_abort) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_CAPTURE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // WAIT cycle counter, restarted on every launch
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt <= 6'd0;
        end else if (r_state == S_LAUNCH) begin
            r_cnt <= 6'd0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + 6'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // operand and core-select latch for MULT/DIV accepts
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_unit_a  <= 32'd0;
            r_unit_b  <= 32'd0;
            r_sel_div <= 1'b0;
        end else if (w_accept & ~io_op.op_code[1]) begin
            r_unit_a  <= io_op.op_a;
            r_unit_b  <= io_op.op_b;
            r_sel_div <= io_op.op_code[0];
        end else begin
            r_unit_a  <= r_unit_a;
            r_unit_b  <= r_unit_b;
            r_sel_div <= r_sel_div;
        end
    end

    // architectural HI/LO
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_capture) begin
            r_hi <= r_sel_div ? i_div_hi : i_mult_hi;
            r_lo <= r_sel_div ? i_div_lo : i_mult_lo;
        end else if (w_accept & (io_op.op_code == OP_MTHI)) begin
            r_hi <= io_op.op_a;
        end else if (w_accept & (io_op.op_code == OP_MTLO)) begin
            r_lo <= io_op.op_a;
        end else begin
            r_hi <= r_hi;
            r_lo <= r_lo;
        end
    end

    // completion pulses
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done  <= w_capture | w_abort | w_trap | (w_accept & io_op.op_code[1]);
            r_error <= w_abort;
        end
    end

    assign io_op.op_ready = (r_state == S_IDLE);
    assign io_op.busy     = (r_state != S_IDLE);
    assign io_op.done     = r_done;
    assign io_op.error    = r_error;
    assign io_op.hi       = r_hi;
    assign io_op.lo       = r_lo;

    assign o_unit_reset  = i_reset | (r_state == S_CLEAR);
    assign o_mult_enable = ~i_reset & (r_state == S_LAUNCH) & ~r_sel_div;
    assign o_div_enable  = ~i_reset & (r_state == S_LAUNCH) & r_sel_div;
    assign o_unit_a      = r_unit_a;
    assign o_unit_b      = r_unit_b;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer with behavioural multiply/divide core models.
module tb_muldiv_sequencer;
    localparam int TO  = 48;
    localparam int INF = 100000;
`ifdef MULDIV_DIVZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_sequencer_if bus();
    logic        unit_reset, mult_enable, div_enable;
    logic [31:0] unit_a, unit_b;
    logic [1:0]  mult_state, div_state;
    logic [31:0] mult_hi, mult_lo, div_hi, div_lo;

    muldiv_sequencer #(.TIMEOUT(TO)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .io_op         (bus),
        .o_unit_reset  (unit_reset),
        .o_mult_enable (mult_enable),
        .o_div_enable  (div_enable),
        .o_unit_a      (unit_a),
        .o_unit_b      (unit_b),
        .i_mult_state  (mult_state),
        .i_div_state   (div_state),
        .i_mult_hi     (mult_hi),
        .i_mult_lo     (mult_lo),
        .i_div_hi      (div_hi),
        .i_div_lo      (div_lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
        logic        dz;
        int          t0;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0, bad = 0, cyc = 0, n_done = 0;
    int          cnt_busy = 0, cnt_ur = 0, cnt_me = 0, cnt_de = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    int          core_lat = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Core models: a core reports DONE lat cycles after its enable, results valid one cycle later.
    // A core that is not running reports DONE with junk results, so the sequencer must ignore it.
    logic        c_run[2];
    logic [1:0]  c_st[2];
    logic        c_val[2];
    int          c_cnt[2];
    int          c_lat[2];
    logic [31:0] c_rh[2], c_rl[2], c_jh[2], c_jl[2];
    wire  [1:0]  c_en = {div_enable, mult_enable};

    function automatic logic [63:0] core_calc(input int c, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     ia, ib;
        ia = a;
        ib = b;
        if (c == 0) begin
            p = longint'(ia) * longint'(ib);
            return p;
        end
        if (ib == 0) return 64'd0;
        return {ia % ib, ia / ib};
    endfunction

    function automatic int eff_lat(input int c);
        if (c == 1 && unit_b == 32'd0) return INF;
        return core_lat;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int c = 0; c < 2; c++) begin
            c_jh[c] <= $urandom;
            c_jl[c] <= $urandom;
            if (unit_reset) begin
                c_run[c] <= 1'b0;
                c_st[c]  <= 2'd0;
                c_val[c] <= 1'b0;
                c_cnt[c] <= 0;
            end else if (c_en[c]) begin
                c_run[c] <= 1'b1;
                c_cnt[c] <= 1;
                c_val[c] <= 1'b0;
                c_lat[c] <= eff_lat(c);
                c_st[c]  <= (eff_lat(c) <= 1) ? 2'd2 : 2'd1;
                {c_rh[c], c_rl[c]} <= core_calc(c, unit_a, unit_b);
            end else if (c_run[c]) begin
                c_cnt[c] <= c_cnt[c] + 1;
                c_st[c]  <= (c_cnt[c] + 1 >= c_lat[c]) ? 2'd2 : 2'd1;
                c_val[c] <= (c_st[c] == 2'd2);
            end
        end
    end

    assign mult_state = c_run[0] ? c_st[0] : 2'd2;
    assign div_state  = c_run[1] ? c_st[1] : 2'd2;
    assign mult_hi    = (c_run[0] && c_val[0]) ? c_rh[0] : c_jh[0];
    assign mult_lo    = (c_run[0] && c_val[0]) ? c_rl[0] : c_jl[0];
    assign div_hi     = (c_run[1] && c_val[1]) ? c_rh[1] : c_jh[1];
    assign div_lo     = (c_run[1] && c_val[1]) ? c_rl[1] : c_jl[1];

    // Monitor: activity counters and scoreboard comparison on every done.
    always @(negedge clk) begin
        if (bus.done) n_done <= n_done + 1;
        if (!rst) begin
            if (bus.busy)   cnt_busy <= cnt_busy + 1;
            if (unit_reset) cnt_ur   <= cnt_ur + 1;
            if (mult_enable) cnt_me  <= cnt_me + 1;
            if (div_enable)  cnt_de  <= cnt_de + 1;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("hi", bus.hi, mon_e.hi);
                    check("lo", bus.lo, mon_e.lo);
                    check("error", bus.error, mon_e.err);
                    check("div_zero", bus.div_zero, mon_e.dz);
                    check("latency", cyc - mon_e.t0, mon_e.lat);
                end
            end else if (bus.error || bus.div_zero) begin
                check("stray_flag", {bus.error, bus.div_zero}, 2'b00);
            end
        end
    end

    // Issue one request, holding op_valid until accepted, and push the architectural result.
    task automatic do_op(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b, input int lat);
        exp_t   e;
        longint p;
        int     ia, ib, guard;
        guard = 0;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_a     = a;
        bus.op_b     = b;
        while (!bus.op_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.op_ready) begin
            check("accept_wait", bus.op_ready, 1'b1);
            bus.op_valid = 1'b0;
            return;
        end
        core_lat = lat;
        ia = a;
        ib = b;
        e.err = 1'b0;
        e.dz  = 1'b0;
        e.t0  = cyc;
        e.lat = lat + 4;
        if (code == 2'b10) begin
            m_hi = a;
            e.lat = 1;
        end else if (code == 2'b11) begin
            m_lo = a;
            e.lat = 1;
        end else if (code == 2'b01 && ib == 0 && TRAP) begin
            e.dz = 1'b1;
            e.lat = 1;
        end else if (lat > TO || (code == 2'b01 && ib == 0)) begin
            e.err = 1'b1;
            e.lat = TO + 3;
        end else if (code == 2'b00) begin
            p = longint'(ia) * longint'(ib);
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else begin
            m_lo = ia / ib;
            m_hi = ia % ib;
        end
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((sb.size() != 0 || !bus.op_ready) && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0 || !bus.op_ready) check("idle_wait", sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          b_busy, b_ur, b_me, b_de, b_done;
        logic [1:0]  r_code;
        logic [31:0] r_a, r_b, s_hi, s_lo;
        int          r_lat;

        bus.op_valid = 1'b0;
        bus.op_code  = 2'b00;
        bus.op_a     = 32'd0;
        bus.op_b     = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_unit_reset", unit_reset, 1'b1);
        check("reset_enables", {mult_enable, div_enable}, 2'b00);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_ready", bus.op_ready, 1'b1);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset_done", {bus.done, bus.error, bus.div_zero}, 3'b000);
        check("reset_operands", {unit_a, unit_b}, 64'd0);
        check("reset_unit_reset_low", unit_reset, 1'b0);

        // MULT 7 * -3, core DONE 33 cycles after enable
        do_op(2'b00, 32'd7, 32'hFFFF_FFFD, 33);
        b_busy = cnt_busy;
        wait_idle(200);
        check("mult_busy_cycles", cnt_busy - b_busy, 36);
        check("mult_hi_value", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo_value", bus.lo, 32'hFFFF_FFEB);

        // DIV 100 / 7
        do_op(2'b01, 32'd100, 32'd7, 20);
        b_ur = cnt_ur; b_me = cnt_me; b_de = cnt_de;
        wait_idle(200);
        check("div_unit_reset_cycles", cnt_ur - b_ur, 1);
        check("div_mult_enable", cnt_me - b_me, 0);
        check("div_div_enable", cnt_de - b_de, 1);
        check("div_lo_value", bus.lo, 32'd14);
        check("div_hi_value", bus.hi, 32'd2);

        // MTHI then MTLO on consecutive cycles
        b_busy = cnt_busy;
        do_op(2'b10, 32'hDEAD_BEEF, 32'd0, 1);
        do_op(2'b11, 32'h1234_5678, 32'd0, 1);
        wait_idle(20);
        check("mt_busy_cycles", cnt_busy - b_busy, 0);
        check("mt_hilo", {bus.hi, bus.lo}, 64'hDEAD_BEEF_1234_5678);

        // DONE on the last WAIT cycle, then one cycle too late, then never
        do_op(2'b00, $urandom, $urandom, TO);
        wait_idle(200);
        s_hi = bus.hi;
        s_lo = bus.lo;
        do_op(2'b00, 32'd5, 32'd6, TO + 1);
        wait_idle(200);
        do_op(2'b01, 32'd9, 32'd2, INF);
        wait_idle(200);
        check("timeout_retains_hilo", {bus.hi, bus.lo}, {s_hi, s_lo});

        // DIV by zero
        do_op(2'b01, 32'd77, 32'd0, 5);
        b_de = cnt_de;
        wait_idle(200);
        check("divzero_div_enable", cnt_de - b_de, TRAP ? 0 : 1);
        check("divzero_retains_hilo", {bus.hi, bus.lo}, {s_hi, s_lo});

        // randomized mix, new requests held while the previous one is busy
        for (int i = 0; i < 24; i++) begin
            r_code = 2'($urandom_range(0, 3));
            r_a = $urandom;
            r_b = $urandom;
            if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 9));
            if (r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) r_b = 32'd3;
            r_lat = ($urandom_range(0, 7) == 0) ? 50 + $urandom_range(0, 10) : $urandom_range(1, 40);
            do_op(r_code, r_a, r_b, r_lat);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_idle(300);

        // reset in WAIT with an ignored request presented while busy
        do_op(2'b10, 32'h0BAD_F00D, 32'd0, 1);
        do_op(2'b00, 32'd3, 32'd4, INF);
        repeat (8) @(posedge clk);
        #1;
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b10;
        bus.op_a     = 32'h55AA_55AA;
        repeat (3) @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        check("busy_in_wait", bus.busy, 1'b1);
        check("ignored_request_hi", bus.hi, 32'h0BAD_F00D);
        rst = 1'b1;
        sb.delete();
        b_done = n_done;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("midreset_no_done", n_done - b_done, 0);
        check("midreset_idle", {bus.busy, bus.op_ready}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
